// File: rtl/udp_pkg.sv
// Shared UDP transmit definitions: payload limit and the datagram length type.
package udp_pkg;
    localparam int UDP_MAX_PAYLOAD = 1472;
    localparam int UDP_LEN_W       = 11;

    typedef logic [UDP_LEN_W-1:0] udp_len_t;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: o_rd_data always presents the oldest entry while not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // NOTE: storage is never reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
endmodule

// File: rtl/udp_tx_buffer.sv
// Byte-wide UDP payload buffer: stores producer datagrams, commits them on last/oversize,
// and presents the oldest committed datagram to the IP core first-word-fall-through.
module udp_tx_buffer
    import udp_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int LEN_AW  = 4,
    parameter int MAX_LEN = UDP_MAX_PAYLOAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] udp_tx_pending_data,
    output logic [7:0]  udp_tx,
    input  logic        udp_tx_rden,
    output logic        dgram_split,
    output logic        rd_underrun
);
    localparam int              RAM_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] RAM_FULL  = (ADDR_W+1)'(RAM_DEPTH);
    localparam udp_len_t        LEN_LIMIT = udp_len_t'(MAX_LEN);

    logic [7:0]        r_ram [RAM_DEPTH];
    logic [7:0]        r_tx;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W:0]   r_used;
    udp_len_t          r_wlen;
    udp_len_t          r_rlen;
    udp_len_t          w_wlen_inc;
    udp_len_t          w_fifo_len;
    logic              r_live;
    logic              r_split;
    logic              r_underrun;
    logic              w_wr_en;
    logic              w_commit;
    logic              w_rden_eff;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // r_live holds in_ready low until the first edge after reset release.
    assign in_ready   = r_live && (r_used != RAM_FULL) && !w_fifo_full;
    assign w_wr_en    = in_valid && in_ready;
    assign w_wlen_inc = r_wlen + udp_len_t'(1);
    assign w_commit   = w_wr_en && (in_last || (w_wlen_inc == LEN_LIMIT));
    assign w_rden_eff = udp_tx_rden && (r_rlen != '0);
    assign w_pop      = (r_rlen == '0) && !w_fifo_empty;
    // Look one byte ahead on a read so udp_tx tracks rd_ptr with no bubble.
    assign w_rd_addr  = w_rden_eff ? (r_rd_ptr + ADDR_W'(1)) : r_rd_ptr;

    sync_fifo #(
        .WIDTH (UDP_LEN_W),
        .AW    (LEN_AW)
    ) u_len_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_commit),
        .i_wr_data (w_wlen_inc),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_len),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ram[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live   <= 1'b0;
            r_wr_ptr <= '0;
            r_wlen   <= '0;
            r_split  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_split <= w_commit && !in_last;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                r_wlen   <= w_commit ? '0 : w_wlen_inc;
            end
        end
    end

    // rlen only reloads from zero, which leaves one idle cycle between datagrams.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_rlen     <= '0;
            r_tx       <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_tx <= r_ram[w_rd_addr];
            if (w_pop) begin
                r_rlen <= w_fifo_len;
            end else if (w_rden_eff) begin
                r_rlen <= r_rlen - udp_len_t'(1);
            end
            if (w_rden_eff) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (udp_tx_rden && (r_rlen == '0)) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // Occupancy includes uncommitted bytes so the producer can never overrun the reader.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_used <= '0;
        end else begin
            case ({w_wr_en, w_rden_eff})
                2'b10:   r_used <= r_used + (ADDR_W+1)'(1);
                2'b01:   r_used <= r_used - (ADDR_W+1)'(1);
                default: r_used <= r_used;
            endcase
        end
    end

    assign udp_tx_pending_data = 16'(r_rlen);
    assign udp_tx              = r_tx;
    assign dgram_split         = r_split;
    assign rd_underrun         = r_underrun;
endmodule

// File: tb/tb_udp_tx_buffer.sv
// Self-checking bench for udp_tx_buffer: directed table, corner sequences and a queue-based model.
module tb_udp_tx_buffer;
    localparam int ADDR_W    = 11;
    localparam int LEN_AW    = 4;
    localparam int MAX_LEN   = 1472;
    localparam int RAM_BYTES = 2 ** ADDR_W;
    localparam int LEN_SLOTS = 2 ** LEN_AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] udp_tx_pending_data;
    logic [7:0]  udp_tx;
    logic        udp_tx_rden = 1'b0;
    logic        dgram_split;
    logic        rd_underrun;

    always #5 clk = ~clk;

    udp_tx_buffer #(
        .ADDR_W  (ADDR_W),
        .LEN_AW  (LEN_AW),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_last             (in_last),
        .in_ready            (in_ready),
        .udp_tx_pending_data (udp_tx_pending_data),
        .udp_tx              (udp_tx),
        .udp_tx_rden         (udp_tx_rden),
        .dgram_split         (dgram_split),
        .rd_underrun         (rd_underrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: committed lengths and unread bytes as plain queues.
    int         m_lens[$];
    logic [7:0] m_data[$];
    int         m_wlen;
    int         m_rlen;
    bit         m_under;
    bit         m_split;
    bit         m_live;

    function automatic void model_reset();
        m_lens.delete();
        m_data.delete();
        m_wlen  = 0;
        m_rlen  = 0;
        m_under = 1'b0;
        m_split = 1'b0;
        m_live  = 1'b0;
    endfunction

    function automatic bit model_ready();
        return m_live && (m_data.size() < RAM_BYTES) && (m_lens.size() < LEN_SLOTS);
    endfunction

    function automatic void model_step(input logic v, input logic l, input logic [7:0] d, input logic rd);
        bit acc;
        bit pop;
        int popped;
        acc    = v && model_ready();
        pop    = (m_rlen == 0) && (m_lens.size() != 0);
        popped = 0;
        if (pop) popped = m_lens.pop_front();
        m_split = 1'b0;
        if (rd) begin
            if (m_rlen > 0) begin
                m_rlen--;
                void'(m_data.pop_front());
            end else begin
                m_under = 1'b1;
            end
        end
        if (pop) m_rlen = popped;
        if (acc) begin
            m_data.push_back(d);
            m_wlen++;
            if (l || m_wlen == MAX_LEN) begin
                m_lens.push_back(m_wlen);
                m_split = !l;
                m_wlen  = 0;
            end
        end
        m_live = 1'b1;
    endfunction

    // Observations of the DUT, taken at each sampling point.
    logic        obs_ready;
    logic [15:0] obs_pending;
    logic        obs_underrun;
    logic [15:0] prev_pending = 16'h0;
    int          split_count = 0;
    int          zero_run = 0;
    int          loads[$];
    int          gaps[$];

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic observe();
        obs_ready    = in_ready;
        obs_pending  = udp_tx_pending_data;
        obs_underrun = rd_underrun;
        if (dgram_split) split_count++;
        if (udp_tx_pending_data != 16'h0 && prev_pending == 16'h0) begin
            loads.push_back(int'(udp_tx_pending_data));
            gaps.push_back(zero_run);
        end
        zero_run     = (udp_tx_pending_data == 16'h0) ? zero_run + 1 : 0;
        prev_pending = udp_tx_pending_data;
    endtask

    task automatic compare_model();
        check("pending", 32'(udp_tx_pending_data), 32'(m_rlen));
        if (m_rlen > 0) check("udp_tx", 32'(udp_tx), 32'(m_data[0]));
        check("in_ready", 32'(in_ready), 32'(model_ready()));
        check("dgram_split", 32'(dgram_split), 32'(m_split));
        check("rd_underrun", 32'(rd_underrun), 32'(m_under));
    endtask

    task automatic cycle(input logic v, input logic l, input logic [7:0] d, input logic rd);
        in_valid    = v;
        in_last     = l;
        in_data     = d;
        udp_tx_rden = rd;
        @(negedge clk);
        compare_model();
        observe();
        @(posedge clk);
        model_step(v, l, d, rd);
        #1;
    endtask

    task automatic write_bytes(input int n);
        int sent;
        int budget;
        bit acc;
        logic [7:0] d;
        sent   = 0;
        budget = n + 200;
        while (sent < n && budget > 0) begin
            d   = 8'($urandom);
            acc = model_ready();
            cycle(1'b1, (sent == n - 1), d, 1'b0);
            if (acc) sent++;
            budget--;
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int c = 0; c < max_cycles && (m_rlen > 0 || m_lens.size() != 0); c++) begin
            cycle(1'b0, 1'b0, 8'h00, (m_rlen > 0));
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pending"}, 32'(udp_tx_pending_data), 32'h0);
        check({tag, "_udp_tx"}, 32'(udp_tx), 32'h0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'h0);
        check({tag, "_split"}, 32'(dgram_split), 32'h0);
        check({tag, "_underrun"}, 32'(rd_underrun), 32'h0);
    endtask

    typedef struct {
        logic       v;
        logic       l;
        logic [7:0] d;
        logic       rd;
        int         exp_pending;
        logic [7:0] exp_tx;
        logic       exp_ready;
    } vec_t;

    vec_t tbl [11];

    task automatic run_table(input string tag);
        for (int i = 0; i < 11; i++) begin
            in_valid    = tbl[i].v;
            in_last     = tbl[i].l;
            in_data     = tbl[i].d;
            udp_tx_rden = tbl[i].rd;
            @(negedge clk);
            check($sformatf("%s_pending[%0d]", tag, i), 32'(udp_tx_pending_data), 32'(tbl[i].exp_pending));
            if (tbl[i].exp_pending != 0)
                check($sformatf("%s_udp_tx[%0d]", tag, i), 32'(udp_tx), 32'(tbl[i].exp_tx));
            check($sformatf("%s_in_ready[%0d]", tag, i), 32'(in_ready), 32'(tbl[i].exp_ready));
            check($sformatf("%s_split[%0d]", tag, i), 32'(dgram_split), 32'h0);
            observe();
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].rd);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepted;

        tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 0, 8'h00, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 0, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 8'h33, 1'b0, 0, 8'h00, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 8'h44, 1'b0, 0, 8'h00, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4, 8'h11, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 8'h22, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 8'h33, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 8'h44, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1};

        // Power-on reset.
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_values("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_model();
        rst_n = 1'b1;
        @(posedge clk);
        model_step(1'b0, 1'b0, 8'h00, 1'b0);
        #1;

        // Four-byte datagram, back-to-back reads.
        run_table("t1");

        // Lengths 1, MAX, 7 in order with a single idle cycle between them.
        loads.delete();
        gaps.delete();
        write_bytes(1);
        write_bytes(MAX_LEN);
        write_bytes(7);
        drain(6000);
        check("s2_nloads", 32'(loads.size()), 32'd3);
        check("s2_load0", 32'(q_at(loads, 0)), 32'd1);
        check("s2_load1", 32'(q_at(loads, 1)), 32'(MAX_LEN));
        check("s2_load2", 32'(q_at(loads, 2)), 32'd7);
        check("s2_gap1", 32'(q_at(gaps, 1)), 32'd1);
        check("s2_gap2", 32'(q_at(gaps, 2)), 32'd1);

        // Oversize datagram is force-committed at MAX_LEN.
        loads.delete();
        gaps.delete();
        split_count = 0;
        write_bytes(1500);
        drain(6000);
        check("s3_split_count", 32'(split_count), 32'd1);
        check("s3_load0", 32'(q_at(loads, 0)), 32'(MAX_LEN));
        check("s3_load1", 32'(q_at(loads, 1)), 32'(1500 - MAX_LEN));

        // Fill the data RAM (pointers already wrapped once), then free one byte.
        write_bytes(RAM_BYTES);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("s4_full_ready", 32'(obs_ready), 32'h0);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("s4_ready_back", 32'(obs_ready), 32'h1);
        drain(6000);

        // One-byte datagrams until the length FIFO stalls; the head one has already left it.
        accepted = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 8'(i + 8'h80), 1'b0);
            if (obs_ready) accepted++;
            else break;
        end
        check("s5_accepts", 32'(accepted), 32'(LEN_SLOTS + 1));
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("s5_underrun", 32'(obs_underrun), 32'h1);
        check("s5_next_len", 32'(obs_pending), 32'h1);
        check("s5_ready_back", 32'(obs_ready), 32'h1);
        drain(2000);

        // Asynchronous reset in the middle of a read and of a partial datagram.
        write_bytes(10);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b1);
        #2;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        udp_tx_rden = 1'b0;
        model_reset();
        #1 check_reset_values("mid");
        @(posedge clk);
        @(negedge clk);
        compare_model();
        rst_n = 1'b1;
        @(posedge clk);
        model_step(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        run_table("t2");

        // Randomised traffic: read-starved phase, then read-heavy phase.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(9) < 7), ($urandom_range(19) == 0), 8'($urandom),
                  (i < 2000) ? ($urandom_range(9) < 2) : ($urandom_range(9) < 8));
        end
        drain(20000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
